// File: rtl/i2c_pkg.sv
// Shared I2C definitions: SCL quarter-phase encoding and default timing constants.
// Imported by the phase generator and by the I2C master.
package i2c_pkg;

    typedef enum logic [1:0] {
        HI1 = 2'd0,
        HI2 = 2'd1,
        LO1 = 2'd2,
        LO2 = 2'd3
    } phase_t;

    localparam int QTR_DEF         = 250;
    localparam int BUS_FREE_DEF    = 470;
    localparam int STRETCH_MAX_DEF = 100000;

    function automatic phase_t next_phase(input phase_t ph);
        phase_t nxt;
        case (ph)
            HI1:     nxt = HI2;
            HI2:     nxt = LO1;
            LO1:     nxt = LO2;
            default: nxt = HI1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchroniser for an asynchronous pad level; both stages reset to RST_VAL.
module i2c_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/i2c_phase_gen.sv
// SCL quarter-phase sequencer with clock-stretch detection, stretch timeout and bus-free detect.
//
//   phase | meaning
//   HI1   | first half of SCL high; rbit follows its last cycle
//   HI2   | second half of SCL high; ne follows
//   LO1   | first half of SCL low; wbit follows
//   LO2   | second half of SCL low; pe follows
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int QTR         = QTR_DEF,
    parameter int BUS_FREE    = BUS_FREE_DEF,
    parameter int STRETCH_MAX = STRETCH_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic scl_in,
    input  logic sda_in,
    output logic pe,
    output logic rbit,
    output logic ne,
    output logic wbit,
    output logic stretch,
    output logic idle,
    output logic scl_sync,
    output logic sda_sync,
    output logic tmo
);

    localparam int CNT_W  = (QTR > 1)         ? $clog2(QTR)         : 1;
    localparam int SCNT_W = (STRETCH_MAX > 1) ? $clog2(STRETCH_MAX) : 1;
    localparam int ICNT_W = (BUS_FREE > 1)    ? $clog2(BUS_FREE)    : 1;

    localparam logic [CNT_W-1:0]  CNT_TC   = CNT_W'(QTR - 1);
    localparam logic [CNT_W-1:0]  CNT_GRD  = CNT_W'(3);
    localparam logic [SCNT_W-1:0] SCNT_TC  = SCNT_W'(STRETCH_MAX - 1);
    localparam logic [ICNT_W-1:0] ICNT_TC  = ICNT_W'(BUS_FREE - 1);

    logic w_scl_sync;
    logic w_sda_sync;
    logic w_hold;
    logic w_tc;
    logic w_bus_high;

    phase_t            r_phase;
    logic [CNT_W-1:0]  r_cnt;
    logic [SCNT_W-1:0] r_scnt;
    logic [ICNT_W-1:0] r_icnt;
    logic              r_pe;
    logic              r_rbit;
    logic              r_ne;
    logic              r_wbit;
    logic              r_tmo;
    logic              r_idle;

    i2c_sync2 #(.RST_VAL(1'b1)) u_sync_scl (
        .clk   (clk),
        .reset (reset),
        .i_d   (scl_in),
        .o_q   (w_scl_sync)
    );

    i2c_sync2 #(.RST_VAL(1'b1)) u_sync_sda (
        .clk   (clk),
        .reset (reset),
        .i_d   (sda_in),
        .o_q   (w_sda_sync)
    );

    // The cnt >= 3 guard in HI1 hides the two-flop delay between releasing SCL and seeing it high.
    assign w_hold = en && !r_tmo && !w_scl_sync &&
                    (((r_phase == HI1) && (r_cnt >= CNT_GRD)) || (r_phase == HI2));
    assign w_tc       = (r_cnt == CNT_TC);
    assign w_bus_high = w_scl_sync && w_sda_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_phase <= HI1;
            r_cnt   <= '0;
            r_scnt  <= '0;
            r_tmo   <= 1'b0;
            r_pe    <= 1'b0;
            r_rbit  <= 1'b0;
            r_ne    <= 1'b0;
            r_wbit  <= 1'b0;
        end else begin
            r_pe   <= 1'b0;
            r_rbit <= 1'b0;
            r_ne   <= 1'b0;
            r_wbit <= 1'b0;
            if (!en) begin
                r_phase <= HI1;
                r_cnt   <= '0;
                r_scnt  <= '0;
                r_tmo   <= 1'b0;
            end else if (w_hold) begin
                if (r_scnt == SCNT_TC) begin
                    r_tmo <= 1'b1;
                end else begin
                    r_scnt <= r_scnt + 1'b1;
                end
            end else begin
                r_scnt <= '0;
                if (w_tc) begin
                    r_cnt   <= '0;
                    r_phase <= next_phase(r_phase);
                    case (r_phase)
                        HI1:     r_rbit <= 1'b1;
                        HI2:     r_ne   <= 1'b1;
                        LO1:     r_wbit <= 1'b1;
                        default: r_pe   <= 1'b1;
                    endcase
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_icnt <= '0;
            r_idle <= 1'b0;
        end else if (!w_bus_high) begin
            r_icnt <= '0;
            r_idle <= 1'b0;
        end else if (r_icnt == ICNT_TC) begin
            r_idle <= 1'b1;
        end else begin
            r_icnt <= r_icnt + 1'b1;
        end
    end

    // Masking with the live line levels drops idle in the very cycle a line goes low.
    assign idle     = r_idle && w_bus_high;
    assign stretch  = w_hold;
    assign pe       = r_pe;
    assign rbit     = r_rbit;
    assign ne       = r_ne;
    assign wbit     = r_wbit;
    assign tmo      = r_tmo;
    assign scl_sync = w_scl_sync;
    assign sda_sync = w_sda_sync;

endmodule

// File: tb/tb_i2c_phase_gen.sv
// Scoreboard bench for i2c_phase_gen: stimulus queues expected events, a negedge monitor matches them.
module tb_i2c_phase_gen;

    localparam int EV_PE       = 0;
    localparam int EV_RBIT     = 1;
    localparam int EV_NE       = 2;
    localparam int EV_WBIT     = 3;
    localparam int EV_STR_RISE = 4;
    localparam int EV_STR_FALL = 5;
    localparam int EV_TMO_RISE = 6;
    localparam int EV_TMO_FALL = 7;
    localparam int EV_IDL_RISE = 8;
    localparam int EV_IDL_FALL = 9;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic scl_in = 1'b1;
    logic sda_in = 1'b0;
    logic pe, rbit, ne, wbit, stretch, idle, scl_sync, sda_sync, tmo;

    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    logic rst_q = 1'b0;
    logic p_str = 1'b0;
    logic p_tmo = 1'b0;
    logic p_idl = 1'b0;
    exp_t exp_q[$];

    i2c_phase_gen #(
        .QTR         (10),
        .BUS_FREE    (20),
        .STRETCH_MAX (100)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .en       (en),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .pe       (pe),
        .rbit     (rbit),
        .ne       (ne),
        .wbit     (wbit),
        .stretch  (stretch),
        .idle     (idle),
        .scl_sync (scl_sync),
        .sda_sync (sda_sync),
        .tmo      (tmo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    function automatic string kname(input int k);
        case (k)
            EV_PE:       return "pe";
            EV_RBIT:     return "rbit";
            EV_NE:       return "ne";
            EV_WBIT:     return "wbit";
            EV_STR_RISE: return "stretch_rise";
            EV_STR_FALL: return "stretch_fall";
            EV_TMO_RISE: return "tmo_rise";
            EV_TMO_FALL: return "tmo_fall";
            EV_IDL_RISE: return "idle_rise";
            default:     return "idle_fall";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int kind);
        int idx;
        idx = -1;
        n_total++;
        foreach (exp_q[i]) begin
            if (idx < 0 && exp_q[i].kind == kind) idx = i;
        end
        if (idx < 0) begin
            n_bad++;
            $display("FAIL %s: seen at cycle %0d, required none", kname(kind), cyc);
        end else begin
            if (exp_q[idx].cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: seen at cycle %0d, required cycle %0d", kname(kind), cyc, exp_q[idx].cyc);
            end
            exp_q.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (!rst_q) begin
                n_total++;
                if ({pe, rbit, ne, wbit, stretch, idle, tmo, scl_sync, sda_sync} != 9'b0000000_11) begin
                    n_bad++;
                    $display("FAIL reset_state: cycle %0d outputs=%b required 000000011", cyc,
                             {pe, rbit, ne, wbit, stretch, idle, tmo, scl_sync, sda_sync});
                end
            end
            if ((32'(pe) + 32'(rbit) + 32'(ne) + 32'(wbit)) > 0) begin
                n_total++;
                if ((32'(pe) + 32'(rbit) + 32'(ne) + 32'(wbit)) > 1) begin
                    n_bad++;
                    $display("FAIL exclusive: cycle %0d pulses=%b required at most one",
                             cyc, {pe, rbit, ne, wbit});
                end
            end
            if (pe)                check_event(EV_PE);
            if (rbit)              check_event(EV_RBIT);
            if (ne)                check_event(EV_NE);
            if (wbit)              check_event(EV_WBIT);
            if (stretch && !p_str) check_event(EV_STR_RISE);
            if (!stretch && p_str) check_event(EV_STR_FALL);
            if (tmo && !p_tmo)     check_event(EV_TMO_RISE);
            if (!tmo && p_tmo)     check_event(EV_TMO_FALL);
            if (idle && !p_idl)    check_event(EV_IDL_RISE);
            if (!idle && p_idl)    check_event(EV_IDL_FALL);
            p_str = stretch;
            p_tmo = tmo;
            p_idl = idle;
        end
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int t_n, t_m, t_p, t_p2, t_q, t_s, t_g;

        // reset held 20 cycles with en high, then released
        goto(20);
        t_n = cyc;
        rst_n = 1'b1;
        expect_ev(EV_RBIT, t_n + 10);

        // en dropped briefly, then a clean rise: full nominal cycle
        goto(t_n + 12);
        en = 1'b0;
        goto(t_n + 17);
        t_m = cyc;
        en = 1'b1;
        expect_ev(EV_RBIT, t_m + 10);
        expect_ev(EV_NE,   t_m + 20);
        expect_ev(EV_WBIT, t_m + 30);
        expect_ev(EV_PE,   t_m + 40);
        expect_ev(EV_RBIT, t_m + 50);
        expect_ev(EV_NE,   t_m + 60);
        expect_ev(EV_WBIT, t_m + 70);
        expect_ev(EV_PE,   t_m + 80);

        // slave holds SCL low for 20 cycles starting at pe
        t_p = t_m + 80;
        goto(t_p);
        scl_in = 1'b0;
        expect_ev(EV_STR_RISE, t_p + 3);
        expect_ev(EV_STR_FALL, t_p + 22);
        expect_ev(EV_RBIT,     t_p + 29);
        expect_ev(EV_NE,       t_p + 39);
        expect_ev(EV_WBIT,     t_p + 49);
        expect_ev(EV_PE,       t_p + 59);
        goto(t_p + 20);
        scl_in = 1'b1;

        // SCL stuck low from pe: timeout, then nominal spacing despite SCL low
        t_p2 = t_p + 59;
        goto(t_p2);
        scl_in = 1'b0;
        expect_ev(EV_STR_RISE, t_p2 + 3);
        expect_ev(EV_TMO_RISE, t_p2 + 103);
        expect_ev(EV_STR_FALL, t_p2 + 103);
        expect_ev(EV_RBIT,     t_p2 + 110);
        expect_ev(EV_NE,       t_p2 + 120);
        expect_ev(EV_WBIT,     t_p2 + 130);
        expect_ev(EV_PE,       t_p2 + 140);
        expect_ev(EV_RBIT,     t_p2 + 150);
        goto(t_p2 + 150);
        scl_in = 1'b1;
        goto(t_p2 + 152);
        en = 1'b0;
        expect_ev(EV_TMO_FALL, t_p2 + 153);
        goto(t_p2 + 153);
        en = 1'b1;
        expect_ev(EV_RBIT, t_p2 + 163);
        expect_ev(EV_NE,   t_p2 + 173);

        // en dropped in LO1 at cnt = 5: wbit and pe must not appear
        goto(t_p2 + 178);
        en = 1'b0;
        goto(t_p2 + 200);
        t_q = cyc;
        en = 1'b1;
        expect_ev(EV_RBIT, t_q + 10);
        goto(t_q + 12);
        en = 1'b0;

        // bus-free detection with a one-cycle SDA glitch
        goto(t_q + 20);
        t_s = cyc;
        sda_in = 1'b1;
        expect_ev(EV_IDL_RISE, t_s + 22);
        goto(t_s + 30);
        t_g = cyc;
        sda_in = 1'b0;
        expect_ev(EV_IDL_FALL, t_g + 2);
        expect_ev(EV_IDL_RISE, t_g + 23);
        goto(t_g + 1);
        sda_in = 1'b1;
        goto(t_g + 70);

        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events: %0d expected events not seen, first %s at cycle %0d, required 0 left",
                     exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_phase_gen.md
I2C_PHASE_GEN -- requirements
Module: i2c_phase_gen

Interface
REQ-001 SHALL have parameter QTR, default 250, meaning clk cycles per SCL quarter-period (100 kHz at 100 MHz); legal range 8..65535.
REQ-002 SHALL have parameter BUS_FREE, default 470, meaning consecutive cycles with both lines high before idle asserts.
REQ-003 SHALL have parameter STRETCH_MAX, default 100000, meaning the maximum continuous stretch cycles before timeout.
REQ-004 SHALL have ports (name direction width meaning):
  clk  in  1  sole clock, rising edge.
  reset  in  1  synchronous, active-low reset.
  en  in  1  run phase sequencer; low holds it parked.
  scl_in  in  1  raw SCL pad level.
  sda_in  in  1  raw SDA pad level.
  pe  out  1  one-cycle pulse at SCL rising edge (drive SCL high).
  rbit  out  1  one-cycle pulse at mid-SCL-high (sample SDA).
  ne  out  1  one-cycle pulse at SCL falling edge (drive SCL low).
  wbit  out  1  one-cycle pulse at mid-SCL-low (change SDA).
  stretch  out  1  slave holding SCL low during the high half.
  idle  out  1  bus free.
  scl_sync  out  1  synchronised SCL.
  sda_sync  out  1  synchronised SDA.
  tmo  out  1  sticky stretch-timeout flag.

Function
REQ-005 SHALL synchronise scl_in and sda_in through 2 flip-flops each; scl_sync and sda_sync are the second-stage outputs.
REQ-006 SHALL sequence the phases HI1 -> HI2 -> LO1 -> LO2 -> HI1, each lasting QTR cycles, using a quarter counter cnt running 0..QTR-1.
REQ-007 SHALL assert one pulse for exactly one cycle in the cycle after the terminal count (cnt == QTR-1) of each phase: HI1 end -> rbit, HI2 end -> ne, LO1 end -> wbit, LO2 end -> pe.
REQ-008 SHALL keep pe, rbit, ne and wbit mutually exclusive; at most one is high in any cycle.
REQ-009 SHALL, while en = 0, hold the phase at HI1 with cnt = 0 and drive no pulses; the first pulse after en rises is rbit, QTR cycles after en is first sampled high.
REQ-010 SHALL, when en falls mid-phase, suppress all pulses from the next cycle and re-park the sequencer at HI1, cnt = 0.
REQ-011 SHALL, in phase HI1 with cnt >= 3, or in phase HI2, hold cnt and drive stretch = 1 while scl_sync = 0; this guard masks synchroniser latency after pe.
REQ-012 SHALL never assert stretch in phases LO1 or LO2.
REQ-013 SHALL count consecutive stretch cycles; on reaching STRETCH_MAX it sets tmo = 1, which remains set until en = 0 or reset.
REQ-014 SHALL ignore stretching while tmo = 1 (stretch stays 0 and cnt advances).
REQ-015 SHALL assert idle once scl_sync = 1 and sda_sync = 1 for BUS_FREE consecutive cycles.
REQ-016 SHALL clear idle, and restart the idle count, in the same cycle that either synchronised line is 0.
REQ-017 SHALL keep idle independent of en.
REQ-018 SHALL size the counters to $clog2 of their respective parameters.
REQ-019 SHALL saturate both the stretch counter and the idle counter; neither wraps.

Reset
REQ-020 SHALL, when reset = 0 at a clk edge, drive pe = rbit = ne = wbit = stretch = idle = tmo = 0.
REQ-021 SHALL, when reset = 0 at a clk edge, set scl_sync = sda_sync = 1, both synchroniser stages = 1, phase = HI1, cnt = 0, and both the stretch count and the idle count = 0.
REQ-022 SHALL give reset priority over en and over all other inputs.
REQ-023 SHALL abort any phase in progress when reset is applied; there is no pulse in the cycle after release.

Structure
REQ-024 SHALL take the phase enumeration (HI1, HI2, LO1, LO2) and the default QTR, BUS_FREE and STRETCH_MAX constants from shared package i2c_pkg, which the master also imports.
REQ-025 SHALL implement the 2-flip-flop synchroniser as sub-module i2c_sync2 (reset value parameterised, here 1), instantiated twice.

Verification
REQ-026 SHALL cover: QTR = 10, en = 1, reset held low 20 cycles -> all pulses 0, idle = 0; after release, rbit fires 10 cycles after en is sampled.
REQ-027 SHALL cover: QTR = 10, scl_in = sda_in = 1, en rises at t0 -> rbit at t0+10, ne at t0+20, wbit at t0+30, pe at t0+40, rbit at t0+50; period 40, never two pulses in one cycle.
REQ-028 SHALL cover: QTR = 10, scl_in forced low for 20 cycles starting at pe -> stretch high for exactly 19 cycles, and rbit is delayed by 19 cycles versus nominal.
REQ-029 SHALL cover: STRETCH_MAX = 100, scl_in held low from pe -> tmo = 1 after 100 stretch cycles, then stretch = 0 and the pulses resume at nominal spacing; en low for 1 cycle clears tmo.
REQ-030 SHALL cover: BUS_FREE = 20, both lines high -> idle rises 22 cycles after the lines settle; a 1-cycle low glitch on sda_in -> idle falls 2 cycles later, then re-asserts 20 cycles after sda_sync returns high.
REQ-031 SHALL cover: en dropped during LO1 at cnt = 5 -> no wbit or pe; en re-raised -> rbit after 10 cycles.
